// File: rtl/mean_unit_pkg.sv
// Shared types and helpers for the block-mean unit.
// Holds the FSM state encoding and the log2 helper used to size datapath registers.
package mean_unit_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Smallest n with 2**n >= value; exact log2 for the power-of-two block sizes used here.
   function automatic int log2_of(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mean_unit_if.sv
// Sample/result bundle for mean_unit: the producer drives samples and the start pulse,
// the unit returns the registered mean and its one-cycle ready strobe.
interface mean_unit_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  start_data_in;
   logic [DATA_WIDTH-1:0] mean_out;
   logic                  ready;

   modport master (output data_in, start_data_in, input mean_out, ready);
   modport slave  (input data_in, start_data_in, output mean_out, ready);
endinterface

// File: rtl/mean_unit.sv
// Block mean: after a start pulse, sums TOTAL_SAMPLES consecutive samples and
// publishes the truncated average with a one-cycle ready pulse.
module mean_unit
   import mean_unit_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int TOTAL_SAMPLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   mean_unit_if.slave  bus
);

   localparam int LOG2_N = log2_of(TOTAL_SAMPLES);
   localparam int ACC_W  = DATA_WIDTH + LOG2_N;

   generate
      if ((TOTAL_SAMPLES < 2) || ((TOTAL_SAMPLES & (TOTAL_SAMPLES - 1)) != 0)) begin : g_bad_total
         $error("mean_unit: TOTAL_SAMPLES must be a power of two and at least 2");
      end
   endgenerate

   state_t                r_state;
   logic [ACC_W-1:0]      r_acc;
   logic [LOG2_N-1:0]     r_cnt;
   logic [DATA_WIDTH-1:0] r_mean;
   logic                  r_ready;

   logic [ACC_W-1:0]      w_sum;
   logic                  w_last;

   // The accumulator is wide enough for TOTAL_SAMPLES full-scale samples, so this sum cannot wrap.
   assign w_sum  = r_acc + ACC_W'(bus.data_in);
   assign w_last = (r_state == ACCUM) && (r_cnt == LOG2_N'(TOTAL_SAMPLES - 1));

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_mean  <= '0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start_data_in) begin
                  r_state <= ACCUM;
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            ACCUM: begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + LOG2_N'(1);
               if (w_last) begin
                  r_mean  <= w_sum[ACC_W-1:LOG2_N];
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mean_out = r_mean;
   assign bus.ready    = r_ready;

endmodule

// File: tb/tb_mean_unit.sv
// Self-checking bench for mean_unit: directed and randomized blocks compared
// against a sum-and-divide reference model.
module tb_mean_unit;
   import mean_unit_pkg::*;

   localparam int DW = 8;
   localparam int N  = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mean_unit_if #(.DATA_WIDTH(DW)) bus ();

   mean_unit #(.DATA_WIDTH(DW), .TOTAL_SAMPLES(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW-1:0] blk [N];
   logic [DW-1:0] exp_mean = '0;

   // Reference: the arithmetic mean of the block, truncated.
   function automatic logic [DW-1:0] model_mean();
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += int'(blk[i]);
      return DW'(s / N);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_ramp(input int base);
      for (int i = 0; i < N; i++) blk[i] = DW'(base + i);
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < N; i++) blk[i] = DW'(v);
   endtask

   // Drives a start cycle (with a junk sample) then the N samples in blk; returns in the ready cycle.
   task automatic send_block(input int extra_start_at, input string tag);
      int bad_ready;
      int bad_hold;
      logic [DW-1:0] prev;
      bad_ready = 0;
      bad_hold  = 0;
      prev      = exp_mean;
      bus.start_data_in = 1'b1;
      bus.data_in       = DW'($urandom);
      step();
      for (int i = 0; i < N; i++) begin
         bus.data_in       = blk[i];
         bus.start_data_in = (i == extra_start_at);
         if (bus.ready !== 1'b0) bad_ready++;
         if (bus.mean_out !== prev) bad_hold++;
         step();
      end
      bus.start_data_in = 1'b0;
      bus.data_in       = DW'($urandom);
      exp_mean = model_mean();
      n_checks++;
      if (bus.ready !== 1'b1) $display("FAIL %s ready_pulse: got %b want 1", tag, bus.ready);
      else n_pass++;
      n_checks++;
      if (bus.mean_out !== exp_mean) $display("FAIL %s mean_out: got %0d want %0d", tag, bus.mean_out, exp_mean);
      else n_pass++;
      n_checks++;
      if (bad_ready != 0) $display("FAIL %s early_ready: got %0d cycles with ready want 0", tag, bad_ready);
      else n_pass++;
      n_checks++;
      if (bad_hold != 0) $display("FAIL %s mean_hold: got %0d cycles changed want 0", tag, bad_hold);
      else n_pass++;
   endtask

   task automatic check_ready_drop(input string tag);
      step();
      n_checks++;
      if (bus.ready !== 1'b0) $display("FAIL %s ready_single: got %b want 0", tag, bus.ready);
      else n_pass++;
      n_checks++;
      if (bus.mean_out !== exp_mean) $display("FAIL %s mean_after: got %0d want %0d", tag, bus.mean_out, exp_mean);
      else n_pass++;
   endtask

   task automatic test_reset();
      bus.data_in = '0;
      bus.start_data_in = 1'b0;
      rst_n = 1'b0;
      #12;
      n_checks++;
      if (bus.mean_out !== '0) $display("FAIL reset mean_out: got %0d want 0", bus.mean_out);
      else n_pass++;
      n_checks++;
      if (bus.ready !== 1'b0) $display("FAIL reset ready: got %b want 0", bus.ready);
      else n_pass++;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_ramp();
      fill_ramp(0);
      send_block(-1, "ramp0");
      check_ready_drop("ramp0");
      fill_ramp(10);
      send_block(-1, "ramp10");
      check_ready_drop("ramp10");
   endtask

   task automatic test_const();
      fill_const(6);
      send_block(-1, "const6");
      check_ready_drop("const6");
      fill_const(255);
      send_block(-1, "const255");
      check_ready_drop("const255");
   endtask

   task automatic test_extra_start();
      fill_ramp(0);
      send_block(20, "extra_start");
      check_ready_drop("extra_start");
   endtask

   task automatic test_reset_mid_block();
      int bad_ready;
      bad_ready = 0;
      fill_ramp(10);
      send_block(-1, "pre_reset");
      check_ready_drop("pre_reset");
      fill_ramp(0);
      bus.start_data_in = 1'b1;
      step();
      bus.start_data_in = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus.data_in = blk[i];
         step();
      end
      bus.data_in = blk[30];
      #2;
      rst_n = 1'b0;
      #1;
      exp_mean = '0;
      n_checks++;
      if (bus.mean_out !== '0) $display("FAIL async_reset mean_out: got %0d want 0", bus.mean_out);
      else n_pass++;
      n_checks++;
      if (bus.ready !== 1'b0) $display("FAIL async_reset ready: got %b want 0", bus.ready);
      else n_pass++;
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < N + 8; i++) begin
         bus.data_in = DW'($urandom);
         step();
         if (bus.ready !== 1'b0) bad_ready++;
      end
      n_checks++;
      if (bad_ready != 0) $display("FAIL reset_discard ready: got %0d pulses want 0", bad_ready);
      else n_pass++;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      send_block(-1, "start_at_release");
      check_ready_drop("start_at_release");
   endtask

   task automatic test_back_to_back();
      fill_ramp(0);
      send_block(-1, "b2b_first");
      fill_ramp(10);
      send_block(-1, "b2b_second");
      check_ready_drop("b2b_second");
   endtask

   task automatic test_random();
      int gap;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < N; i++) blk[i] = DW'($urandom);
         send_block(-1, "random");
         gap = int'($urandom_range(0, 3));
         if (gap > 0) begin
            check_ready_drop("random");
            for (int g = 1; g < gap; g++) step();
         end
      end
      check_ready_drop("random_end");
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_const();
      test_extra_start();
      test_reset_mid_block();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mean_unit.md
MEAN_UNIT -- requirements
Module: mean_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each sample and of the result.
REQ-002 Parameter TOTAL_SAMPLES, default 64: samples per block; SHALL be a power of two, at least 2 (elaboration-time assertion).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  DATA_WIDTH  unsigned sample, one per cycle during accumulation.
REQ-006 start_data_in  input  1  one-cycle pulse that opens a new block.
REQ-007 mean_out  output  DATA_WIDTH  registered mean of the last completed block.
REQ-008 ready  output  1  registered one-cycle pulse marking a new valid mean_out.

Function
REQ-009 States SHALL be IDLE and ACCUM; the block SHALL leave reset in IDLE.
REQ-010 IDLE with start_data_in=1 at a rising edge SHALL go to ACCUM, clear the accumulator and clear the sample counter; data_in in the start cycle SHALL NOT be accumulated.
REQ-011 In ACCUM, every rising edge SHALL add data_in, zero-extended, to the accumulator and increment the counter; valid samples are required on exactly TOTAL_SAMPLES consecutive cycles, with no stall or valid input.
REQ-012 The accumulator SHALL be DATA_WIDTH+log2(TOTAL_SAMPLES) bits wide and SHALL never overflow.
REQ-013 The counter SHALL be log2(TOTAL_SAMPLES) bits wide; when it holds TOTAL_SAMPLES-1 and a sample is captured, the block is complete.
REQ-014 On the edge capturing the last sample, mean_out SHALL load (accumulator + data_in) >> log2(TOTAL_SAMPLES), truncated with no rounding; ready SHALL go high for that following cycle only; the state SHALL return to IDLE.
REQ-015 Result latency: ready and the new mean_out are visible in the cycle immediately after the last sample cycle, which is TOTAL_SAMPLES+1 cycles after the start cycle.
REQ-016 mean_out SHALL hold its value until the next block completes or until reset.
REQ-017 start_data_in asserted while in ACCUM SHALL be ignored, and the current block SHALL continue unaffected.
REQ-018 start_data_in asserted in the cycle where ready is high SHALL be accepted, so blocks can run back-to-back.
REQ-019 ready SHALL never be high for two consecutive cycles.

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, accumulator 0, counter 0, mean_out 0 and ready 0, independent of clk.
REQ-021 Reset during ACCUM SHALL discard the partial block; no ready SHALL follow until a new start_data_in completes a full block.
REQ-022 Release of rst_n SHALL take effect at the next rising edge; start_data_in in that cycle SHALL be honoured.

Structure
REQ-023 A shared package SHALL hold the state enum (IDLE, ACCUM) and a log2 helper constant/function for TOTAL_SAMPLES.
REQ-024 The block SHALL be a single module with no sub-modules: counter, accumulator, FSM and output registers are inline.

Verification
REQ-025 Reset, 1-cycle start pulse, then samples 0..63 -> ready pulses once, one cycle after sample 63; mean_out=31 (2016/64 truncated).
REQ-026 Next block with start and samples 10..73 -> mean_out=41 (2656/64 truncated); mean_out stays 31 until that ready.
REQ-027 Start, then 64 samples of 6 -> mean_out=6; all 64 samples of 255 -> mean_out=255, with no overflow.
REQ-028 Extra start pulse at sample 20 of a block of 0..63 -> ignored; single ready with mean_out=31.
REQ-029 rst_n low at sample 30 -> mean_out=0 and ready=0 immediately; no ready follows; a new full block of 0..63 -> mean_out=31.
REQ-030 Start asserted during the ready cycle, then samples 10..73 -> second ready exactly 65 cycles later with mean_out=41.
